// File: rtl/monkey_kbd_pkg.sv
// ============================================================================
// monkey_kbd_pkg -- PS/2 set-2 scan codes, prefix FSM states and direction
// masks shared by the monkey key decoder.
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

package monkey_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  // Direction vectors are packed as {up, down, left, right}.
  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_UP:    m[DIR_UP]    = 1'b1;
      SC_DOWN:  m[DIR_DOWN]  = 1'b1;
      SC_LEFT:  m[DIR_LEFT]  = 1'b1;
      SC_RIGHT: m[DIR_RIGHT] = 1'b1;
      default:  m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] wasd_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      SC_W:    m[DIR_UP]    = 1'b1;
      SC_S:    m[DIR_DOWN]  = 1'b1;
      SC_A:    m[DIR_LEFT]  = 1'b1;
      SC_D:    m[DIR_RIGHT] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/monkey_key_decoder.sv
// ============================================================================
// monkey_key_decoder -- PS/2 arrow-key decoder producing frame-stable motion
// levels. Optional WASD support is enabled by defining MONKEY_KEY_WASD_EN.
// Revision: 1.0 -- initial release
// ============================================================================
`default_nettype none

module monkey_key_decoder
  import monkey_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [7:0] keyCode,
  input  logic       keyValid,
  output logic       leftPressed,
  output logic       rightPressed,
  output logic       upPressed,
  output logic       downPressed,
  output logic       anyPressed
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  kbd_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       arrow_q, arrow_d;
  logic [3:0]       raw_q, raw_d;
  logic [3:0]       dir_q;
  logic             any_q;

`ifdef MONKEY_KEY_WASD_EN
  logic [3:0] wasd_q, wasd_d;
  assign raw_q = arrow_q | wasd_q;
  assign raw_d = arrow_d | wasd_d;
`else
  assign raw_q = arrow_q;
  assign raw_d = arrow_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arrow_d = arrow_q;
`ifdef MONKEY_KEY_WASD_EN
    wasd_d  = wasd_q;
`endif
    if (keyValid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (keyCode == SC_EXT) begin
            state_d = ST_EXT;
          end else if (keyCode == SC_BRK) begin
            state_d = ST_BRK;
          end else begin
`ifdef MONKEY_KEY_WASD_EN
            wasd_d = wasd_q | wasd_mask(keyCode);
`endif
            state_d = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (keyCode == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else if (keyCode == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            arrow_d = arrow_q | arrow_mask(keyCode);
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          // A stray E0 after F0 is dropped rather than treated as a break.
`ifdef MONKEY_KEY_WASD_EN
          if (keyCode != SC_EXT) begin
            wasd_d = wasd_q & ~wasd_mask(keyCode);
          end
`endif
          state_d = ST_IDLE;
        end
        default: begin
          arrow_d = arrow_q & ~arrow_mask(keyCode);
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      arrow_q <= '0;
`ifdef MONKEY_KEY_WASD_EN
      wasd_q  <= '0;
`endif
      dir_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arrow_q <= arrow_d;
`ifdef MONKEY_KEY_WASD_EN
      wasd_q  <= wasd_d;
`endif
      any_q   <= |raw_d;
      // Frame latch samples pre-update flags; opposing pairs cancel out.
      if (startOfFrame) begin
        dir_q[DIR_UP]    <= raw_q[DIR_UP]    & ~raw_q[DIR_DOWN];
        dir_q[DIR_DOWN]  <= raw_q[DIR_DOWN]  & ~raw_q[DIR_UP];
        dir_q[DIR_LEFT]  <= raw_q[DIR_LEFT]  & ~raw_q[DIR_RIGHT];
        dir_q[DIR_RIGHT] <= raw_q[DIR_RIGHT] & ~raw_q[DIR_LEFT];
      end
    end
  end

  assign upPressed    = dir_q[DIR_UP];
  assign downPressed  = dir_q[DIR_DOWN];
  assign leftPressed  = dir_q[DIR_LEFT];
  assign rightPressed = dir_q[DIR_RIGHT];
  assign anyPressed   = any_q;

endmodule

`default_nettype wire

// File: doc/monkey_key_decoder.md
MONKEY_KEY_DECODER -- requirements
Module: monkey_key_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 50000, idle clocks after which a pending E0/F0 prefix is discarded.
REQ-002 Port: clk  input  1  system clock; the block's only clock.
REQ-003 Port: resetN  input  1  reset, asynchronous and active-low.
REQ-004 Port: startOfFrame  input  1  one-clock pulse at each frame start (30 Hz).
REQ-005 Port: keyCode  input  8  PS/2 set-2 scan byte from the serial receiver.
REQ-006 Port: keyValid  input  1  one-clock strobe; keyCode is valid only in that cycle.
REQ-007 Port: leftPressed/rightPressed/upPressed/downPressed  output  1 each  frame-stable direction levels to the monkey motion stage.
REQ-008 Port: anyPressed  output  1  OR of the four raw key states, not frame-latched.

Function
REQ-009 The decoder SHALL use a prefix FSM with states IDLE, EXT, BRK and EXT_BRK, advancing only on cycles where keyValid=1.
REQ-010 In IDLE: E0 -> EXT; F0 -> BRK; any other byte SHALL be handled as a normal make and the FSM SHALL stay in IDLE.
REQ-011 In EXT: F0 -> EXT_BRK; E0 -> stay in EXT; any other byte SHALL be handled as an extended make -> IDLE.
REQ-012 In BRK: any byte SHALL be handled as a normal break -> IDLE, except E0, which SHALL be discarded -> IDLE.
REQ-013 In EXT_BRK: any byte SHALL be handled as an extended break -> IDLE.
REQ-014 Extended make sets and extended break clears these raw flags: 75=up, 72=down, 6B=left, 74=right. Unlisted codes SHALL change no flag.
REQ-015 Raw flags SHALL update on the clock edge that samples keyValid=1 (one-cycle latency).
REQ-016 A saturating timeout counter SHALL run while the FSM is outside IDLE and SHALL clear on every keyValid.
REQ-017 When the counter reaches TIMEOUT_CYCLES-1, the FSM SHALL return to IDLE with no flag change.
REQ-018 The four outputs SHALL load from the raw flags only on startOfFrame cycles and hold between pulses.
REQ-019 If keyValid and startOfFrame are both 1 in the same cycle, the outputs SHALL take the pre-update raw values; the new value appears at the next pulse.
REQ-020 Opposing-direction neutralisation: raw left=right=1 SHALL latch both left and right outputs as 0. Up/down SHALL be treated the same way.
REQ-021 anyPressed SHALL equal the OR of the raw flags, registered, with one-cycle latency from keyValid.

Reset
REQ-022 resetN=0 SHALL asynchronously force: FSM=IDLE, timeout counter=0, all raw flags=0, all outputs=0, anyPressed=0.
REQ-023 A reset asserted mid-sequence (for example after E0 F0) SHALL discard the pending prefix; the next byte after release SHALL be decoded from IDLE.

Configuration
REQ-024 Macro MONKEY_KEY_WASD_EN: when defined, normal make/break of 1D=up, 1B=down, 1C=left, 23=right SHALL also drive the raw flags.
REQ-025 When MONKEY_KEY_WASD_EN is defined, arrow and WASD sources for one direction SHALL be tracked separately and ORed, so releasing one keeps the direction held while the other is down.
REQ-026 When MONKEY_KEY_WASD_EN is undefined, normal codes SHALL never affect any flag and no WASD state SHALL be synthesised.

Structure
REQ-027 Package monkey_kbd_pkg SHALL hold the FSM state enum and all scan-code constants (E0, F0, arrow codes, WASD codes).
REQ-028 The design SHALL be a single module with no sub-module; the timeout counter and FSM are inline.

Verification
REQ-029 Bytes E0,6B, then one startOfFrame pulse -> leftPressed=1; bytes E0,F0,6B, then a pulse -> leftPressed=0.
REQ-030 Hold left (E0,6B), then add right (E0,74), then a pulse -> left=right=0; release left (E0,F0,6B), then a pulse -> right=1.
REQ-031 E0,75 sent in the same cycle as startOfFrame -> upPressed stays 0 that frame and becomes 1 at the next pulse; anyPressed=1 one cycle after the strobe.
REQ-032 E0 followed by TIMEOUT_CYCLES idle clocks, then 75 -> no flag change, FSM back in IDLE.
REQ-033 Bytes E0,F0, then resetN pulsed low, then 72 -> all outputs 0 and downPressed not set.
REQ-034 With MONKEY_KEY_WASD_EN: 1C and E0,6B both made, then F0,1C -> leftPressed stays 1 at the next pulse; without the macro, 1C alone -> leftPressed=0.
